// File: rtl/riscv_defs.sv
// ----------------------------------------------------------------------------
// riscv_defs
// Shared definitions for the load/store unit: RV32I load/store funct3
// encodings, access-size decode, LSU FSM state encoding, and helpers that
// decide request legality and build the byte-enable / replicated write data.
// No ports (package).
// ----------------------------------------------------------------------------
package riscv_defs;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0] for both loads and stores
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // A request is legal when its funct3 exists for its direction and the
    // address is naturally aligned for the access size.
    function automatic logic lsu_req_legal(input logic       write,
                                           input logic [2:0] funct3,
                                           input logic [1:0] byte_off);
        logic f3_ok;
        logic misaligned;
        if (write) f3_ok = funct3 inside {F3_SB, F3_SH, F3_SW};
        else       f3_ok = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        misaligned = ((funct3[1:0] == SZ_HALF) && byte_off[0]) ||
                     ((funct3[1:0] == SZ_WORD) && (byte_off != 2'b00));
        return f3_ok && !misaligned;
    endfunction

    function automatic logic [3:0] lsu_lane_be(input logic [1:0] size,
                                               input logic [1:0] byte_off);
        case (size)
            SZ_BYTE: return 4'b0001 << byte_off;
            SZ_HALF: return byte_off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the memory only needs mem_be
    // to pick the bytes it writes.
    function automatic logic [31:0] lsu_lane_wdata(input logic [1:0]  size,
                                                   input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// lsu_core_if / lsu_mem_if
// Bus bundles for the load/store unit.
//   lsu_core_if : core <-> LSU request/response handshake.
//                 master = core (drives req_*), slave = LSU.
//   lsu_mem_if  : LSU <-> data memory.
//                 master = LSU (drives mem_req/we/addr/wdata/be),
//                 slave  = memory (drives mem_rdata/mem_ack).
// ----------------------------------------------------------------------------
interface lsu_core_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, stall, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, stall, resp_valid, resp_rdata, resp_error
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Combinational load-data aligner: picks the addressed byte/halfword lane out
// of the memory word and sign- or zero-extends it according to funct3.
//   funct3_i   : load funct3 (LB/LH/LW/LBU/LHU)
//   byte_off_i : address bits [1:0] of the load
//   word_i     : word returned by memory
//   data_o     : extended load result
// ----------------------------------------------------------------------------
module lsu_align
    import riscv_defs::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case so that no path leaves it unassigned (which infers a latch).
        data_o   = word_i;
        byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
        half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// RV32I load/store unit. Accepts one request at a time from the core, checks
// funct3 and alignment, performs a single memory access with a bounded wait
// for mem_ack, and returns a one-cycle response pulse.
//   clk, reset : clock, asynchronous active-high reset
//   core       : lsu_core_if.slave  (req_* in; req_ready, stall, resp_* out)
//   mem        : lsu_mem_if.master  (mem_req/we/addr/wdata/be out;
//                                    mem_rdata, mem_ack in)
// Parameter TIMEOUT_CYCLES : ACCESS cycles to wait for mem_ack before error.
// ----------------------------------------------------------------------------
module load_store_unit
    import riscv_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    lsu_core_if.slave   core,
    lsu_mem_if.master   mem
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    // Latched request fields needed after acceptance
    logic             write_q;
    logic [2:0]       funct3_q;
    logic [1:0]       byte_off_q;

    // Registered bus outputs
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [3:0]       mem_be_q;
    logic             resp_valid_q;
    logic             resp_error_q;
    logic [31:0]      resp_rdata_q;

    logic             req_legal_d;
    logic [1:0]       req_size_d;
    logic [31:0]      load_data_d;

    assign req_size_d  = core.req_funct3[1:0];
    assign req_legal_d = lsu_req_legal(core.req_write, core.req_funct3,
                                       core.req_addr[1:0]);

    lsu_align u_align (
        .funct3_i   (funct3_q),
        .byte_off_i (byte_off_q),
        .word_i     (mem.mem_rdata),
        .data_o     (load_data_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            byte_off_q   <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_be_q     <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of statement
            // order in this block.
            unique case (state_q)
                ST_IDLE: begin
                    if (core.req_valid) begin
                        write_q    <= core.req_write;
                        funct3_q   <= core.req_funct3;
                        byte_off_q <= core.req_addr[1:0];
                        if (req_legal_d) begin
                            state_q     <= ST_ACCESS;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= core.req_write;
                            mem_addr_q  <= {core.req_addr[31:2], 2'b00};
                            mem_be_q    <= lsu_lane_be(req_size_d, core.req_addr[1:0]);
                            mem_wdata_q <= lsu_lane_wdata(req_size_d, core.req_wdata);
                        end else begin
                            // Illegal requests never touch memory
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (mem.mem_ack) begin
                        state_q      <= ST_RESP;
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_be_q     <= 4'b0000;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b0;
                        resp_rdata_q <= write_q ? 32'h0 : load_data_d;
                    end else if (cnt_q == CNT_LAST) begin
                        // This was the last allowed ACCESS cycle without ack
                        state_q      <= ST_RESP;
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_be_q     <= 4'b0000;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b1;
                        resp_rdata_q <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_error_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core.req_ready  = (state_q == ST_IDLE);
    // Stall is combinational on req_valid so the core freezes in the same
    // cycle it presents the request; masked during reset.
    assign core.stall      = !reset && (((state_q == ST_IDLE) && core.req_valid) ||
                                        (state_q == ST_ACCESS));
    assign core.resp_valid = resp_valid_q;
    assign core.resp_error = resp_error_q;
    assign core.resp_rdata = resp_rdata_q;

    assign mem.mem_req     = mem_req_q;
    assign mem.mem_we      = mem_we_q;
    assign mem.mem_addr    = mem_addr_q;
    assign mem.mem_wdata   = mem_wdata_q;
    assign mem.mem_be      = mem_be_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum number of ACCESS cycles to wait for mem_ack.
REQ-002 SHALL have one clock; reset is asynchronous and active-high. Ports: clk, reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 req_valid  input  1  core presents a load/store.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I load/store funct3.
REQ-008 req_addr  input  32  byte address from the ALU result.
REQ-009 req_wdata  input  32  store data (rs2).
REQ-010 req_ready  output  1  unit is idle and can accept a request.
REQ-011 stall  output  1  core shall hold PC and operands.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_error  output  1  misaligned access, illegal funct3, or timeout; valid with resp_valid.
REQ-015 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-016 mem_addr  output  32  word address, {req_addr[31:2],2'b00}.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_be  output  4  byte enables.
REQ-019 mem_rdata  input  32  read word; mem_ack  input  1  access complete.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-021 IDLE: req_ready=1. On req_valid, the unit SHALL latch the request. On a legal request it SHALL go to ACCESS; on an illegal one it SHALL go to RESP with error set.
REQ-022 Legal funct3 values: loads 0,1,2,4,5; stores 0,1,2. All other values SHALL be treated as errors.
REQ-023 Misalignment SHALL be flagged for halfword with addr[0]=1, and for word with addr[1:0]!=0.
REQ-024 ACCESS: mem_req=1 with stable addr/we/be/wdata until mem_ack. On ack the unit SHALL capture and extend the read data, then go to RESP.
REQ-025 Byte lanes: byte be=1<<addr[1:0], wdata={4{wdata[7:0]}}. Half be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}. Word be=1111.
REQ-026 Loads SHALL select the lane by addr[1:0]. LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word through.
REQ-027 A timeout counter SHALL count ACCESS cycles. After TIMEOUT_CYCLES cycles without ack, mem_req SHALL drop and the unit SHALL go to RESP with error set.
REQ-028 RESP: resp_valid=1 for exactly one cycle, then the unit SHALL return to IDLE. req_ready=0 during RESP.
REQ-029 stall SHALL equal (IDLE && req_valid) || ACCESS; stall SHALL be low in RESP.
REQ-030 Latency: with ack in the first ACCESS cycle, resp_valid SHALL assert 2 cycles after acceptance. For an illegal request, resp_valid SHALL assert 1 cycle after acceptance.
REQ-031 mem_ack outside ACCESS SHALL be ignored. Request input changes outside IDLE SHALL be ignored.
REQ-032 mem_req SHALL never assert for an illegal request.

Reset
REQ-033 While reset is high: state=IDLE; counter=0; mem_req, mem_we, resp_valid, resp_error, stall = 0; mem_be=0; mem_addr, mem_wdata, resp_rdata = 0.
REQ-034 Reset asserted mid-ACCESS SHALL drop mem_req immediately and SHALL produce no resp_valid.

Structure
REQ-035 The funct3 load/store encodings and FSM state encodings SHALL live in the shared riscv_defs package.
REQ-036 Lane selection and extension SHALL be a combinational sub-module, lsu_align, instantiated once.
REQ-037 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-038 SB, addr 0x9, wdata 0xAAAAAAAA, ack next cycle -> mem_addr 0x8, mem_be 0010, mem_wdata 0xAAAAAAAA; resp_valid with error 0.
REQ-039 SW, addr 0xC, wdata 0xBBBBBBBB -> mem_be 1111, mem_we 1; LH at addr 0x1 -> no mem_req, resp_error 1 one cycle after acceptance.
REQ-040 LB at addr 0x3, mem_rdata 0x80FF1234 -> resp_rdata 0xFFFFFF80; LBU with the same inputs -> 0x00000080.
REQ-041 LH at addr 0x2, mem_rdata 0x8001FFFF -> resp_rdata 0xFFFF8001; LHU -> 0x00008001.
REQ-042 LW with mem_ack held low -> mem_req high for 16 cycles, then resp_error 1 with resp_rdata 0.
REQ-043 Reset pulse during ACCESS -> mem_req 0 same cycle, no resp_valid; the next request completes normally.
